// File: rtl/l1_mem_responder.sv
// On-chip stand-in memory answering the core's split icache/dcache read/write/resp protocol.
// Optional L1_MEM_ADDR_CHECK_EN adds a sticky addr_err flag for misaligned or out-of-range accesses.
module l1_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_read,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_rdata,
  output logic        icache_resp,
  input  logic        dcache_read,
  input  logic        dcache_write,
  input  logic [3:0]  dcache_byte_enable,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  output logic [31:0] dcache_rdata,
`ifdef L1_MEM_ADDR_CHECK_EN
  output logic        dcache_resp,
  output logic        addr_err
`else
  output logic        dcache_resp
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]            i_state, i_state_next, d_state, d_state_next;
  logic [CNT_W-1:0]      i_cnt, i_cnt_next, d_cnt, d_cnt_next;
  logic                  i_done_c, d_done_c, d_req_c, live;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;

  assign i_idx   = icache_addr[ADDR_WIDTH+1:2];
  assign d_idx   = dcache_addr[ADDR_WIDTH+1:2];
  assign d_req_c = dcache_read | dcache_write;

  // Instruction port next-state; completion is the edge on which the counter runs out.
  always_comb begin
    i_state_next = i_state;
    i_cnt_next   = i_cnt;
    i_done_c     = 1'b0;
    case (i_state)
      IDLE: begin
        if (icache_read) begin
          if (LATENCY <= 1) begin
            if (live) begin
              i_done_c     = 1'b1;
              i_state_next = RESP;
            end
          end else begin
            i_state_next = WAIT;
            i_cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!icache_read) begin
          i_state_next = IDLE;
          i_cnt_next   = '0;
        end else if (i_cnt <= CNT_W'(1)) begin
          i_done_c     = 1'b1;
          i_state_next = RESP;
          i_cnt_next   = '0;
        end else begin
          i_cnt_next = i_cnt - CNT_W'(1);
        end
      end
      default: begin
        i_state_next = IDLE;
        i_cnt_next   = '0;
      end
    endcase
  end

  // Data port next-state, same sequencing as the instruction port.
  always_comb begin
    d_state_next = d_state;
    d_cnt_next   = d_cnt;
    d_done_c     = 1'b0;
    case (d_state)
      IDLE: begin
        if (d_req_c) begin
          if (LATENCY <= 1) begin
            if (live) begin
              d_done_c     = 1'b1;
              d_state_next = RESP;
            end
          end else begin
            d_state_next = WAIT;
            d_cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!d_req_c) begin
          d_state_next = IDLE;
          d_cnt_next   = '0;
        end else if (d_cnt <= CNT_W'(1)) begin
          d_done_c     = 1'b1;
          d_state_next = RESP;
          d_cnt_next   = '0;
        end else begin
          d_cnt_next = d_cnt - CNT_W'(1);
        end
      end
      default: begin
        d_state_next = IDLE;
        d_cnt_next   = '0;
      end
    endcase
  end

  // live keeps a single-cycle-latency access from completing on the edge that releases reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state      <= IDLE;
      d_state      <= IDLE;
      i_cnt        <= '0;
      d_cnt        <= '0;
      icache_resp  <= 1'b0;
      dcache_resp  <= 1'b0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
      live         <= 1'b0;
    end else begin
      live        <= 1'b1;
      i_state     <= i_state_next;
      d_state     <= d_state_next;
      i_cnt       <= i_cnt_next;
      d_cnt       <= d_cnt_next;
      icache_resp <= i_done_c;
      dcache_resp <= d_done_c;
      if (i_done_c) icache_rdata <= mem[i_idx];
      if (d_done_c && dcache_read) dcache_rdata <= mem[d_idx];
    end
  end

  // Array has no reset; done is never asserted while the FSMs are held in reset.
  always_ff @(posedge clk) begin
    if (d_done_c && dcache_write) begin
      for (int b = 0; b < 4; b++) begin
        if (dcache_byte_enable[b]) mem[d_idx][8*b +: 8] <= dcache_wdata[8*b +: 8];
      end
    end
  end

`ifdef L1_MEM_ADDR_CHECK_EN
  logic i_bad_c, d_bad_c;
  assign i_bad_c = (icache_addr[1:0] != 2'b00) || (icache_addr[31:ADDR_WIDTH+2] != '0);
  assign d_bad_c = (dcache_addr[1:0] != 2'b00) || (dcache_addr[31:ADDR_WIDTH+2] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_err <= 1'b0;
    else if ((i_done_c && i_bad_c) || (d_done_c && d_bad_c)) addr_err <= 1'b1;
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[1:0], icache_addr[31:ADDR_WIDTH+2],
                              dcache_addr[1:0], dcache_addr[31:ADDR_WIDTH+2]};
`endif

endmodule

// File: tb/tb_l1_mem_responder.sv
// Scoreboard bench for l1_mem_responder: stimulus pushes expected responses, a monitor pops on resp.
module tb_l1_mem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic        dcache_read;
  logic        dcache_write;
  logic [3:0]  dcache_byte_enable;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic [31:0] dcache_rdata;
  logic        dcache_resp;
`ifdef L1_MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  // bit 32 set: compare rdata against bits 31:0; clear: only a resp is expected
  logic [32:0] iq[$];
  logic [32:0] dq[$];

  l1_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_byte_enable(dcache_byte_enable), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata),
`ifdef L1_MEM_ADDR_CHECK_EN
    .dcache_resp(dcache_resp), .addr_err(addr_err)
`else
    .dcache_resp(dcache_resp)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every resp pulse must match the oldest outstanding expectation for its port.
  always @(negedge clk) begin
    logic [32:0] e;
    if (icache_resp) begin
      if (iq.size() == 0) chk("icache_unexpected_resp", 32'd1, 32'd0);
      else begin
        e = iq.pop_front();
        if (e[32]) chk("icache_rdata", icache_rdata, e[31:0]);
      end
    end
    if (dcache_resp) begin
      if (dq.size() == 0) chk("dcache_unexpected_resp", 32'd1, 32'd0);
      else begin
        e = dq.pop_front();
        if (e[32]) chk("dcache_rdata", dcache_rdata, e[31:0]);
      end
    end
  end

  task automatic iread(input logic [31:0] addr, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    iq.push_back({1'b1, exp});
    icache_addr = addr;
    icache_read = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!icache_resp && n < 20);
    icache_read = 1'b0;
    chk("icache_latency", 32'(n), 32'(LAT));
    @(posedge clk);
  endtask

  task automatic daccess(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic chk_data, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    dq.push_back({chk_data, exp});
    dcache_addr        = addr;
    dcache_wdata       = wdata;
    dcache_byte_enable = be;
    dcache_read        = rd;
    dcache_write       = wr;
    do begin
      @(posedge clk); #1; n++;
    end while (!dcache_resp && n < 20);
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    chk("dcache_latency", 32'(n), 32'(LAT));
    @(posedge clk);
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    daccess(1'b0, 1'b1, be, addr, wdata, 1'b0, 32'd0);
  endtask

  task automatic dread(input logic [31:0] addr, input logic [31:0] exp);
    daccess(1'b1, 1'b0, 4'h0, addr, 32'd0, 1'b1, exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    icache_read = 1'b0; icache_addr = '0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_byte_enable = '0;
    dcache_addr = '0; dcache_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_icache_resp", 32'(icache_resp), 32'd0);
    chk("reset_dcache_resp", 32'(dcache_resp), 32'd0);
    chk("reset_icache_rdata", icache_rdata, 32'd0);
    chk("reset_dcache_rdata", dcache_rdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Preload the words the scenarios rely on.
    dwrite(32'h0000_0010, 32'h0000_0013, 4'hF);
    dwrite(32'h0000_0040, 32'h1122_3344, 4'hF);
    dwrite(32'h0000_0080, 32'h0000_0000, 4'hF);
    dwrite(32'h0000_0000, 32'hCAFE_0000, 4'hF);

    iread(32'h0000_0010, 32'h0000_0013);

    // Partial byte-lane write.
    dwrite(32'h0000_0040, 32'hAABB_CCDD, 4'b0101);
    dread(32'h0000_0040, 32'h11BB_33DD);

    // Same-edge completion: instruction port sees the pre-write word.
    fork
      iread(32'h0000_0080, 32'h0000_0000);
      dwrite(32'h0000_0080, 32'hDEAD_BEEF, 4'hF);
    join
    dread(32'h0000_0080, 32'hDEAD_BEEF);
    iread(32'h0000_0080, 32'hDEAD_BEEF);

    // Read and write together: write wins, rdata returns the old word.
    daccess(1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'h0102_0304, 1'b1, 32'h11BB_33DD);
    dread(32'h0000_0040, 32'h11BB_0304);

    // Empty byte mask completes but changes nothing.
    dwrite(32'h0000_0010, 32'hFFFF_FFFF, 4'h0);
    dread(32'h0000_0010, 32'h0000_0013);

    // Aborted write: dropped after acceptance, before completion.
    @(negedge clk);
    dcache_addr = 32'h0000_0010; dcache_wdata = 32'hFFFF_FFFF;
    dcache_byte_enable = 4'hF; dcache_write = 1'b1;
    @(posedge clk); #1;
    dcache_write = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dcache_resp) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    dread(32'h0000_0010, 32'h0000_0013);

    // Reset while a write sits in WAIT.
    @(negedge clk);
    dcache_addr = 32'h0000_0040; dcache_wdata = 32'h0000_0000;
    dcache_byte_enable = 4'hF; dcache_write = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_dcache_resp", 32'(dcache_resp), 32'd0);
    chk("async_rst_dcache_rdata", dcache_rdata, 32'd0);
    chk("async_rst_icache_rdata", icache_rdata, 32'd0);
    dcache_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    dread(32'h0000_0040, 32'h11BB_0304);

`ifdef L1_MEM_ADDR_CHECK_EN
    chk("addr_err_clean", 32'(addr_err), 32'd0);
    iread(32'h0000_1002, 32'hCAFE_0000);
    chk("addr_err_set", 32'(addr_err), 32'd1);
    iread(32'h0000_0010, 32'h0000_0013);
    chk("addr_err_sticky", 32'(addr_err), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("addr_err_rst", 32'(addr_err), 32'd0);
    rst = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("icache_queue_drained", 32'(iq.size()), 32'd0);
    chk("dcache_queue_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_responder.md
Name: l1_mem_responder

Overview:
- Synthesizable memory-side responder for the core's split instruction and data cache request interfaces.
- Answers the same read/write/resp protocol the core drives on its instruction and data ports.
- Used as an on-chip stand-in memory for FPGA bring-up and unit benches, replacing the behavioural magic memory.
- Holds one word-addressed array shared by both ports; each port has its own latency state machine.

Parameters:
- ADDR_WIDTH, 10, word-index bits; array depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request acceptance to resp; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_read  in  1  instruction read request; held high until icache_resp.
- icache_addr  in  32  instruction byte address.
- icache_rdata  out  32  instruction word; valid only while icache_resp is high.
- icache_resp  out  1  one-cycle completion pulse, instruction port.
- dcache_read  in  1  data read request; held high until dcache_resp.
- dcache_write  in  1  data write request; held high until dcache_resp.
- dcache_byte_enable  in  4  byte mask for writes; bit i enables byte lane [8i+7:8i].
- dcache_addr  in  32  data byte address.
- dcache_wdata  in  32  write data.
- dcache_rdata  out  32  read word; valid only while dcache_resp is high.
- dcache_resp  out  1  one-cycle completion pulse, data port.

Behaviour:
- Reset: icache_resp=0, dcache_resp=0, icache_rdata=0, dcache_rdata=0, both FSMs IDLE, wait counters 0. The array is not cleared.
- Reset asserted mid-operation abandons the request immediately. No write is performed.
- Word index is addr[ADDR_WIDTH+1:2]. addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so out-of-range addresses alias modulo depth.
- Each port FSM states: IDLE, WAIT, RESP.
- IDLE -> WAIT when that port's request is high. Counter loads LATENCY-1. The cycle of acceptance is t.
- WAIT decrements the counter each cycle.
- On the edge where the counter is 0, the FSM enters RESP. On that same edge:
  - a read request registers the array word into rdata;
  - a write request updates enabled byte lanes only.
- RESP drives resp=1 for exactly one cycle (cycle t+LATENCY), then -> IDLE.
- A request still high in the IDLE cycle after RESP is a new request. Back-to-back throughput is one access per LATENCY+1 cycles.
- Request deasserted while in WAIT: abort to IDLE; no resp; no write.
- Address, wdata and byte_enable are sampled on the completing edge, not at acceptance. The initiator must hold them stable.
- dcache_read and dcache_write both high: treated as a write; dcache_rdata is loaded with the pre-write word.
- A write with byte_enable=0000 completes with resp and leaves memory unchanged.
- Both ports complete on the same edge at the same word: the instruction port returns the pre-write (old) word, and the write still commits.
- Ports are fully independent: no arbitration stalls; the array has one write port and two read ports.
- rdata holds its last value outside resp cycles. Benches must not check it then.

Optional Feature:
- Macro L1_MEM_ADDR_CHECK_EN.
- Defined: adds output addr_err (1 bit, reset 0), a sticky flag cleared only by rst. It sets on any completing access where addr[1:0]!=0 or any address bit above ADDR_WIDTH+1 is nonzero. The access still completes normally with aliased addressing.
- Undefined: no addr_err port and no check logic.

Test Plan:
- Reset, LATENCY=2, icache_read=1, addr 0x0000_0010 holding 0x0000_0013 -> icache_resp high exactly cycle t+2, icache_rdata=0x0000_0013, resp low at t+3.
- dcache_write addr 0x40, wdata 0xAABBCCDD, mbe 0101 over old 0x11223344, then read 0x40 -> reads 0x11BB33DD.
- Same-edge completion: dcache write 0xDEADBEEF (mbe 1111) and icache read of the same word (old 0x00000000) -> icache_rdata=0x00000000, a later read returns 0xDEADBEEF.
- dcache_read dropped after one WAIT cycle (LATENCY=3) -> no dcache_resp ever; next request completes at its own t+3.
- rst pulsed during a write in WAIT -> outputs 0 asynchronously, target word unchanged afterwards.
- With L1_MEM_ADDR_CHECK_EN, read of 0x0000_1002 (ADDR_WIDTH=10) -> completes aliased to word 0, addr_err=1 and stays 1 until rst.
